// File: rtl/rtype_exec.sv
// R-type execute/writeback sequencer: IDLE->READ->EXEC->WB, one instruction per 4 cycles, write at accept+3.
// Accepts only in IDLE (instr_ready); upstream holds instr_valid while not ready.
module rtype_exec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             Rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [4:0]       regA,
    output logic [4:0]       regB,
    input  logic [31:0]      Adat,
    input  logic [31:0]      Bdat,
    output logic [4:0]       regW,
    output logic [31:0]      Wdat,
    output logic             RegWrite,
    output logic             done,
    output logic             ovf,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] instr_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic        ovf_flag;
    logic        ill_flag;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        alu_ill;
    logic        in_flight;

    assign opcode = instr_q[31:26];
    assign rs     = instr_q[25:21];
    assign rt     = instr_q[20:16];
    assign rd     = instr_q[15:11];
    assign shamt  = instr_q[10:6];
    assign funct  = instr_q[5:0];

    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (instr_valid) state_nxt = READ;
            READ:    state_nxt = EXEC;
            EXEC:    state_nxt = WB;
            WB:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ALU works on the captured operands so the register file read path is off the critical loop.
    always_comb begin
        alu_res = 32'd0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        if (opcode != 6'd0) begin
            alu_ill = 1'b1;
        end else begin
            case (funct)
                F_SLL:  alu_res = b_q << shamt;
                F_SRL:  alu_res = b_q >> shamt;
                F_SRA:  alu_res = $unsigned($signed(b_q) >>> shamt);
                F_SLLV: alu_res = b_q << a_q[4:0];
                F_SRLV: alu_res = b_q >> a_q[4:0];
                F_SRAV: alu_res = $unsigned($signed(b_q) >>> a_q[4:0]);
                F_ADD: begin
                    alu_res = sum;
                    alu_ovf = (a_q[31] == b_q[31]) && (sum[31] != a_q[31]);
                end
                F_ADDU: alu_res = sum;
                F_SUB: begin
                    alu_res = diff;
                    alu_ovf = (a_q[31] != b_q[31]) && (diff[31] != a_q[31]);
                end
                F_SUBU: alu_res = diff;
                F_AND:  alu_res = a_q & b_q;
                F_OR:   alu_res = a_q | b_q;
                F_XOR:  alu_res = a_q ^ b_q;
                F_NOR:  alu_res = ~(a_q | b_q);
                F_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                F_SLTU: alu_res = {31'd0, a_q < b_q};
                default: alu_ill = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            instr_q     <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            result_q    <= 32'd0;
            ovf_flag    <= 1'b0;
            ill_flag    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (state == IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (state == READ) begin
                a_q <= Adat;
                b_q <= Bdat;
            end
            if (state == EXEC) begin
                result_q <= alu_res;
                ovf_flag <= alu_ovf;
                ill_flag <= alu_ill;
            end
            if (RegWrite) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs decode straight from state so an async reset drops them, including RegWrite, at once.
    assign in_flight = (state != IDLE);

    always_comb begin
        instr_ready = (state == IDLE);
        regA        = in_flight ? rs : 5'd0;
        regB        = in_flight ? rt : 5'd0;
        regW        = 5'd0;
        Wdat        = 32'd0;
        RegWrite    = 1'b0;
        done        = 1'b0;
        ovf         = 1'b0;
        illegal     = 1'b0;
        if (state == WB) begin
            regW     = rd;
            Wdat     = result_q;
            RegWrite = !ovf_flag && !ill_flag && (rd != 5'd0);
            done     = 1'b1;
            ovf      = ovf_flag;
            illegal  = ill_flag;
        end
    end

endmodule

// File: tb/tb_rtype_exec.sv
// Directed bench for rtype_exec with a behavioural register file (rN=N after load).
module tb_rtype_exec;

    logic        clk;
    logic        Rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  regA;
    logic [4:0]  regB;
    logic [31:0] Adat;
    logic [31:0] Bdat;
    logic [4:0]  regW;
    logic [31:0] Wdat;
    logic        RegWrite;
    logic        done;
    logic        ovf;
    logic        illegal;
    logic [15:0] retired_cnt;

    int total;
    int bad;
    int exp_cnt;
    int n;

    logic [31:0] rf [32];
    logic        rf_load;

    rtype_exec #(.CNT_W(16)) dut (
        .clk         (clk),
        .Rst_n       (Rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .regA        (regA),
        .regB        (regB),
        .Adat        (Adat),
        .Bdat        (Bdat),
        .regW        (regW),
        .Wdat        (Wdat),
        .RegWrite    (RegWrite),
        .done        (done),
        .ovf         (ovf),
        .illegal     (illegal),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i);
        end else if (RegWrite && regW != 5'd0) begin
            rf[regW] <= Wdat;
        end
    end

    assign Adat = rf[regA];
    assign Bdat = rf[regB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},    32'(instr_ready), 32'd1);
        chk({tag, "_regA"},     32'(regA), 32'd0);
        chk({tag, "_regB"},     32'(regB), 32'd0);
        chk({tag, "_regW"},     32'(regW), 32'd0);
        chk({tag, "_Wdat"},     Wdat, 32'd0);
        chk({tag, "_RegWrite"}, 32'(RegWrite), 32'd0);
        chk({tag, "_done"},     32'(done), 32'd0);
        chk({tag, "_ovf"},      32'(ovf), 32'd0);
        chk({tag, "_illegal"},  32'(illegal), 32'd0);
        chk({tag, "_cnt"},      32'(retired_cnt), 32'd0);
    endtask

    // Issues one instruction and checks each of its four cycles plus the committed result.
    task automatic do_instr(input string tag, input logic [31:0] ins, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic exp_we,
                            input logic [31:0] exp_wd, input logic exp_ovf, input logic exp_ill);
        logic [31:0] old_rd;
        old_rd = rf[rd];
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_read"}, 32'(instr_ready), 32'd0);
        chk({tag, "_regA"}, 32'(regA), 32'(rs));
        chk({tag, "_regB"}, 32'(regB), 32'(rt));
        chk({tag, "_we_read"}, 32'(RegWrite), 32'd0);
        @(negedge clk);
        chk({tag, "_done_exec"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, "_done_wb"}, 32'(done), 32'd1);
        chk({tag, "_we_wb"}, 32'(RegWrite), 32'(exp_we));
        chk({tag, "_regW"}, 32'(regW), 32'(rd));
        chk({tag, "_Wdat"}, Wdat, exp_wd);
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
        chk({tag, "_regA_wb"}, 32'(regA), 32'(rs));
        if (exp_we) exp_cnt++;
        @(negedge clk);
        chk({tag, "_done_after"}, 32'(done), 32'd0);
        chk({tag, "_ready_after"}, 32'(instr_ready), 32'd1);
        chk({tag, "_cnt"}, 32'(retired_cnt), 32'(exp_cnt));
        if (rd != 5'd0) begin
            chk({tag, "_rf"}, rf[rd], exp_we ? exp_wd : old_rd);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        total       = 0;
        bad         = 0;
        exp_cnt     = 0;
        n           = 0;
        Rst_n       = 1'b0;
        rf_load     = 1'b1;
        instr       = 32'd0;
        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rf_load = 1'b0;
        Rst_n   = 1'b1;

        do_instr("add",   32'h00221820, 5'd1, 5'd2, 5'd3, 1'b1, 32'h00000003, 1'b0, 1'b0);
        do_instr("sll",   32'h000127C0, 5'd0, 5'd1, 5'd4, 1'b1, 32'h80000000, 1'b0, 1'b0);
        do_instr("subov", 32'h00812822, 5'd4, 5'd1, 5'd5, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
        do_instr("sra",   32'h00043103, 5'd0, 5'd4, 5'd6, 1'b1, 32'hF8000000, 1'b0, 1'b0);
        do_instr("slt",   32'h0081382A, 5'd4, 5'd1, 5'd7, 1'b1, 32'h00000001, 1'b0, 1'b0);
        do_instr("sltu",  32'h0081382B, 5'd4, 5'd1, 5'd7, 1'b1, 32'h00000000, 1'b0, 1'b0);
        do_instr("nor",   32'h00224027, 5'd1, 5'd2, 5'd8, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0);
        do_instr("srav",  32'h00244807, 5'd1, 5'd4, 5'd9, 1'b1, 32'hC0000000, 1'b0, 1'b0);
        do_instr("illop", 32'h20010005, 5'd0, 5'd1, 5'd0, 1'b0, 32'h00000000, 1'b0, 1'b1);
        do_instr("illfn", 32'h00225001, 5'd1, 5'd2, 5'd10, 1'b0, 32'h00000000, 1'b0, 1'b1);
        do_instr("rd0",   32'h00220020, 5'd1, 5'd2, 5'd0, 1'b0, 32'h00000003, 1'b0, 1'b0);

        // Abort add $10,$1,$2 with reset asserted during EXEC.
        @(negedge clk);
        instr       = 32'h00225020;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        chk("abort_we_held", 32'(RegWrite), 32'd0);
        Rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_rel", 32'(instr_ready), 32'd1);
        chk("abort_rf10", rf[10], 32'd10);
        chk("abort_cnt", 32'(retired_cnt), 32'd0);

        // Back-to-back: addu $11,$1,$2 then sub $12,$2,$1 with instr_valid held high.
        @(negedge clk);
        instr       = 32'h00225821;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr = 32'h00416022;
        n = 0;
        while (n < 10) begin
            @(posedge clk);
            #1 n++;
            if (regA == 5'd2) break;
        end
        instr_valid = 1'b0;
        chk("b2b_gap", 32'(n), 32'd4);
        repeat (4) @(negedge clk);
        chk("b2b_rf11", rf[11], 32'd3);
        chk("b2b_rf12", rf[12], 32'd1);
        chk("b2b_cnt", 32'(retired_cnt), 32'd2);
        chk("b2b_ready", 32'(instr_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
